// File: rtl/accum_stage_16.sv
// accum_stage_16: sequential add/subtract accumulator built on csa_16.
//
// Accepts 16-bit operands over in_valid/in_ready and folds each one into a
// running accumulator. It adds or subtracts according to in_sub. After NUM_OPS
// operands, or earlier on in_last, it presents the group result over
// out_valid/out_ready.
//
// Optional feature: define ACCUM_SAT_EN for saturating arithmetic. On an
// overflow or borrow the accumulator clamps to 16'hFFFF (add) or 16'h0000
// (subtract). When the macro is undefined the accumulator wraps modulo 2^16.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_data             16-bit unsigned operand
//   in_sub              1 = subtract in_data, 0 = add
//   in_last             operand closes the group early
//   out_valid/out_ready result handshake
//   out_sum             accumulated result (16 bit)
//   out_ovf             sticky overflow/borrow flag for the group
//   out_cnt             operands in the group (8 bit)

// 16-bit carry select adder: 4-bit blocks, each block precomputes its sum for both carry-in values.
module csa_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    localparam int unsigned BLK_W = 4;
    localparam int unsigned N_BLK = 4;
    localparam int unsigned SUM_W = BLK_W + 1;

    logic [N_BLK:0] carry;

    assign carry[0] = c_in;

    for (genvar g = 0; g < N_BLK; g++) begin : g_blk
        logic [SUM_W-1:0] s0;
        logic [SUM_W-1:0] s1;

        assign s0 = SUM_W'(a[g*BLK_W +: BLK_W]) + SUM_W'(b[g*BLK_W +: BLK_W]);
        assign s1 = SUM_W'(a[g*BLK_W +: BLK_W]) + SUM_W'(b[g*BLK_W +: BLK_W]) + SUM_W'(1);

        assign sum[g*BLK_W +: BLK_W] = carry[g] ? s1[BLK_W-1:0] : s0[BLK_W-1:0];
        assign carry[g+1]            = carry[g] ? s1[BLK_W]     : s0[BLK_W];
    end

    assign c_out = carry[N_BLK];
endmodule

module accum_stage_16 #(
    parameter int unsigned NUM_OPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sub,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_ovf,
    output logic [7:0]  out_cnt
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] acc_upd;
    logic              c;
    logic              ev;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic              close;

    // Subtraction is acc + ~in_data + 1. A missing carry-out then means a borrow.
    assign b_op = in_sub ? ~in_data : in_data;

    csa_16 u_csa (
        .a     (acc),
        .b     (b_op),
        .c_in  (in_sub),
        .sum   (acc_nxt),
        .c_out (c)
    );

    assign ev      = c ^ in_sub;
    assign accept  = in_valid & in_ready;
    assign cnt_inc = cnt + CNT_W'(1);
    assign close   = (cnt_inc == CNT_W'(NUM_OPS)) | in_last;

`ifdef ACCUM_SAT_EN
    // Clamp toward the side the result ran off.
    assign acc_upd = ev ? (in_sub ? DATA_W'(0) : {DATA_W{1'b1}}) : acc_nxt;
`else
    assign acc_upd = acc_nxt;
`endif

    // Control state and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= acc_upd;
                        ovf <= ovf | ev;
                        cnt <= cnt_inc;
                        if (close) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= ACC;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    // Handshake flags decode straight from the state flop. Result outputs come straight from their registers.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_cnt   = cnt;
endmodule

// File: tb/tb_accum_stage_16.sv
module tb_accum_stage_16;
    localparam int unsigned NUM_OPS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model of the open group, kept as plain integers.
    int m_acc = 0;
    bit m_ovf = 1'b0;
    int m_cnt = 0;

    accum_stage_16 #(.NUM_OPS(NUM_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operand to the reference: exact integer arithmetic, then wrap or clamp.
    task automatic model_apply(input logic [15:0] d, input logic sub);
        int s;
        s = sub ? (m_acc - int'(d)) : (m_acc + int'(d));
        if (s < 0 || s > 65535) begin
            m_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
            s = (s < 0) ? 0 : 65535;
`else
            s = (s < 0) ? s + 65536 : s - 65536;
`endif
        end
        m_acc = s;
        m_cnt++;
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
    endtask

    // Present one operand and hold it until it is accepted.
    task automatic send(input logic [15:0] d, input logic sub, input logic last);
        int n;
        bit closes;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom();
        in_sub   = 1'($urandom());
        in_last  = 1'($urandom());
        model_apply(d, sub);
        closes = (m_cnt == int'(NUM_OPS)) || last;
        check("send_out_valid", 32'(out_valid), 32'(closes));
    endtask

    // Result must be up right after the closing accept. Stall for hold cycles, then take it.
    task automatic expect_result(input int hold);
        logic [15:0] s0;
        check("res_valid", 32'(out_valid), 32'd1);
        check("res_in_ready", 32'(in_ready), 32'd0);
        check("res_sum", 32'(out_sum), 32'(m_acc));
        check("res_ovf", 32'(out_ovf), 32'(m_ovf));
        check("res_cnt", 32'(out_cnt), 32'(m_cnt));
        s0 = out_sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(i % 2 == 0);
            in_data  = $urandom();
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(out_sum), 32'(s0));
            check("hold_cnt", 32'(out_cnt), 32'(m_cnt));
            check("hold_ovf", 32'(out_ovf), 32'(m_ovf));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_sum_clr", 32'(out_sum), 32'd0);
        model_clear();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        do_reset();

        // Back-to-back 1,2,3,4 with out_ready already high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_sum", 32'(out_sum), 32'd10);
        check("t1_ovf", 32'(out_ovf), 32'd0);
        check("t1_cnt", 32'(out_cnt), 32'd4);
        tick();
        check("t1_valid_drop", 32'(out_valid), 32'd0);
        check("t1_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Add overflow closed early by in_last.
        send(16'hFFF0, 1'b0, 1'b0);
        send(16'h0020, 1'b0, 1'b1);
`ifdef ACCUM_SAT_EN
        check("t2_sum_const", 32'(out_sum), 32'h0000FFFF);
`else
        check("t2_sum_const", 32'(out_sum), 32'h00000010);
`endif
        check("t2_ovf_const", 32'(out_ovf), 32'd1);
        check("t2_cnt_const", 32'(out_cnt), 32'd2);
        expect_result(0);

        // Subtract borrow, then a clean add/sub group.
        send(16'd5, 1'b0, 1'b0);
        send(16'd7, 1'b1, 1'b1);
`ifdef ACCUM_SAT_EN
        check("t3_sum_const", 32'(out_sum), 32'h00000000);
`else
        check("t3_sum_const", 32'(out_sum), 32'h0000FFFE);
`endif
        check("t3_ovf_const", 32'(out_ovf), 32'd1);
        expect_result(0);
        send(16'd9, 1'b0, 1'b0);
        send(16'd4, 1'b1, 1'b1);
        check("t3b_sum_const", 32'(out_sum), 32'd5);
        check("t3b_ovf_const", 32'(out_ovf), 32'd0);
        expect_result(0);

        // Stall in DONE for 5 cycles while in_valid toggles. The next group must start from zero.
        send(16'd100, 1'b0, 1'b0);
        send(16'd50, 1'b1, 1'b1);
        expect_result(5);
        send(16'd3, 1'b0, 1'b1);
        check("t4_fresh_sum", 32'(out_sum), 32'd3);
        expect_result(0);

        // Reset mid-group drops the partial result.
        send(16'd20, 1'b0, 1'b0);
        send(16'd30, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) send(16'd1, 1'b0, 1'b0);
        check("t5_sum_const", 32'(out_sum), 32'd4);
        expect_result(0);

        // Operand presented during reset is discarded.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd7;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check("t6_cnt_after_rst", 32'(out_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send(16'd3, 1'b0, 1'b0);
        check("t6_sum_const", 32'(out_sum), 32'd12);
        expect_result(0);

        // In_last on the NUM_OPS-th operand closes once.
        for (int i = 0; i < 3; i++) send(16'd2, 1'b0, 1'b0);
        send(16'd2, 1'b0, 1'b1);
        expect_result(1);
        check("t7_no_double", 32'(out_valid), 32'd0);

        // Randomized groups against the reference model.
        for (int g = 0; g < 20; g++) begin
            bit closed;
            closed = 1'b0;
            while (!closed) begin
                logic [15:0] d;
                logic        sub;
                logic        last;
                d    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65000, 65535)) : 16'($urandom());
                sub  = 1'($urandom());
                last = ($urandom_range(0, 4) == 0);
                send(d, sub, last);
                closed = last || (m_cnt == int'(NUM_OPS));
                if (!closed && $urandom_range(0, 2) == 0) tick();
            end
            expect_result(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
